spram_access_ctrl: RTL and testbench

- Request/response front-end that sits directly upstream of the team's single-port RAM (en=1 write, en=0 registered read).
- Accepts read/write commands over a valid/ready request channel and sequences the RAM's en/addr/data_in pins.
- Captures the RAM's registered read data and returns it on a valid/ready response channel; keeps wrapping transaction counters for debug.

---
 rtl/spram_pkg.sv | 17 +
 rtl/single_port_ram.sv | 28 ++
 rtl/spram_access_ctrl.sv | 136 +++++++++++++
 tb/tb_spram_access_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// Shared definitions for the single-port RAM, its access controller and benches.
//   SPRAM_DATA_WIDTH / SPRAM_ADDR_WIDTH : default RAM geometry
//   spram_state_e                       : access-controller FSM state encoding
package spram_pkg;

  localparam int unsigned SPRAM_DATA_WIDTH = 8;
  localparam int unsigned SPRAM_ADDR_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_CAP  = 3'd3,
    ST_RSP  = 3'd4
  } spram_state_e;

endpackage

// File: rtl/single_port_ram.sv
// Single-port RAM, no reset.
//   clk     : clock, rising edge
//   en      : 1 = write data_in to mem[addr]; 0 = registered read of mem[addr]
//   addr    : word address
//   data_in : write data
//   data    : registered read data (updates only on cycles with en = 0)
module single_port_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= data_in;
    end else begin
      data <= mem[addr];
    end
  end

endmodule

// File: rtl/spram_access_ctrl.sv
// Request/response front-end for single_port_ram.
//   clk, rst_n                    : clock (rising edge), async active-low reset
//   req_valid/req_ready           : request handshake
//   req_we/req_addr/req_wdata     : command (1 = write), address, write data
//   rsp_valid/rsp_ready/rsp_data  : read-response handshake and data
//   ram_en/ram_addr/ram_wdata     : RAM control (ram_en = 1 writes)
//   ram_rdata                     : RAM registered read data
//   wr_done_cnt/rd_done_cnt       : wrapping completed-write / completed-read counters
// All outputs are registered except req_ready, which decodes the state.
module spram_access_ctrl
  import spram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPRAM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = SPRAM_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [CNT_WIDTH-1:0]  wr_done_cnt,
  output logic [CNT_WIDTH-1:0]  rd_done_cnt
);

  spram_state_e state_q, state_d;

  logic                  ram_en_q,    ram_en_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic [CNT_WIDTH-1:0]  wr_cnt_q,    wr_cnt_d;
  logic [CNT_WIDTH-1:0]  rd_cnt_q,    rd_cnt_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_valid) state_d = req_we ? ST_WR : ST_RD;
      ST_WR:   state_d = ST_IDLE;
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = ST_RSP;
      ST_RSP:  if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values. ram_en is only ever high for the single
  // WR cycle; every other state defaults it low so the RAM just reads.
  always_comb begin
    ram_en_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          ram_addr_d = req_addr;
          if (req_we) begin
            ram_wdata_d = req_wdata;
            ram_en_d    = 1'b1;
          end
        end
      end
      ST_WR: begin
        wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
      end
      ST_RD: begin
      end
      ST_CAP: begin
        rsp_data_d  = ram_rdata;
        rsp_valid_d = 1'b1;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rd_cnt_d    = rd_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      ram_en_q    <= ram_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign ram_en      = ram_en_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign wr_done_cnt = wr_cnt_q;
  assign rd_done_cnt = rd_cnt_q;

endmodule

// File: tb/tb_spram_access_ctrl.sv
module tb_spram_access_ctrl;
  import spram_pkg::*;

  localparam int unsigned DW = SPRAM_DATA_WIDTH;
  localparam int unsigned AW = SPRAM_ADDR_WIDTH;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_we, rsp_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          req_ready, rsp_valid, ram_en;
  logic [DW-1:0] rsp_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [CW-1:0] wr_cnt, rd_cnt;

  logic          req_ready2, rsp_valid2, ram_en2;
  logic [DW-1:0] rsp_data2, ram_wdata2, ram_rdata2;
  logic [AW-1:0] ram_addr2;
  logic [1:0]    wr_cnt2, rd_cnt2;

  int checks = 0;
  int errors = 0;
  int exp_wr = 0;
  int exp_rd = 0;

  always #5 clk = ~clk;

  spram_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .wr_done_cnt(wr_cnt), .rd_done_cnt(rd_cnt)
  );

  single_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_ram (
    .clk(clk), .en(ram_en), .addr(ram_addr), .data_in(ram_wdata), .data(ram_rdata)
  );

  // Narrow-counter instance driven by the same stimulus, used for the wrap test.
  spram_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready2), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2),
    .ram_en(ram_en2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2),
    .wr_done_cnt(wr_cnt2), .rd_done_cnt(rd_cnt2)
  );

  single_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_ram2 (
    .clk(clk), .en(ram_en2), .addr(ram_addr2), .data_in(ram_wdata2), .data(ram_rdata2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait (bounded) for the accept edge; returns at E0+1.
  task automatic present(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    present(1'b1, a, d);
    tick();
    exp_wr++;
  endtask

  // Read with rsp_ready high; lat = edges after accept until rsp_valid seen.
  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    rsp_ready = 1'b1;
    present(1'b0, a, '0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    d = rsp_data;
    tick();
    exp_rd++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    exp_wr = 0;
    exp_rd = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    #1;
    checks++;
    if ({ram_en, ram_addr, ram_wdata, rsp_valid, rsp_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en=%0b addr=%0h wdata=%0h rsp_valid=%0b rsp_data=%0h required all 0",
               ram_en, ram_addr, ram_wdata, rsp_valid, rsp_data);
    end
    checks++;
    if (wr_cnt !== '0 || rd_cnt !== '0) begin
      errors++;
      $display("FAIL reset_counters: wr=%0d rd=%0d required 0 0", wr_cnt, rd_cnt);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_ready: got %0b required 1", req_ready);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d;
    int lat;
    present(1'b1, 4'd3, 8'hA5);
    checks++;
    if (ram_en !== 1'b1 || ram_addr !== 4'd3 || ram_wdata !== 8'hA5 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_issue: en=%0b addr=%0h wdata=%0h ready=%0b required 1 3 a5 0",
               ram_en, ram_addr, ram_wdata, req_ready);
    end
    tick();
    exp_wr++;
    checks++;
    if (ram_en !== 1'b0 || req_ready !== 1'b1 || wr_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL wr_done: en=%0b ready=%0b wr_cnt=%0d required 0 1 1", ram_en, req_ready, wr_cnt);
    end
    do_read(4'd3, d, lat);
    checks++;
    if (d !== 8'hA5) begin
      errors++;
      $display("FAIL rd_data: got %0h required a5", d);
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL rd_latency: got %0d edges after accept required 2", lat);
    end
    checks++;
    if (rd_cnt !== CW'(1) || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_done: rd_cnt=%0d rsp_valid=%0b ready=%0b required 1 0 1", rd_cnt, rsp_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    logic [DW-1:0] expd;
    int lat;
    int bad_ready = 0;
    int bad_data = 0;
    req_valid = 1'b1;
    req_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_addr = AW'(i);
      req_wdata = DW'(i) ^ 8'h5A;
      if (req_ready !== 1'b1) bad_ready++;
      tick();
      if (req_ready !== 1'b0 || ram_en !== 1'b1) bad_ready++;
      tick();
    end
    req_valid = 1'b0;
    exp_wr += 16;
    checks++;
    if (bad_ready != 0) begin
      errors++;
      $display("FAIL b2b_ready_pattern: %0d bad cycles required 0", bad_ready);
    end
    checks++;
    if (wr_cnt !== CW'(exp_wr)) begin
      errors++;
      $display("FAIL b2b_wr_cnt: got %0d required %0d", wr_cnt, exp_wr);
    end
    for (int i = 0; i < 16; i++) begin
      do_read(AW'(i), d, lat);
      expd = DW'(i) ^ 8'h5A;
      if (d !== expd || lat != 2) begin
        bad_data++;
        $display("FAIL b2b_readback_%0d: data=%0h lat=%0d required %0h 2", i, d, lat, expd);
      end
    end
    checks++;
    if (bad_data != 0) errors++;
    checks++;
    if (rd_cnt !== CW'(exp_rd)) begin
      errors++;
      $display("FAIL b2b_rd_cnt: got %0d required %0d", rd_cnt, exp_rd);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad = 0;
    do_write(4'd7, 8'h3C);
    rsp_ready = 1'b0;
    present(1'b0, 4'd7, '0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h3C || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d: valid=%0b data=%0h ready=%0b required 1 3c 0",
                 i, rsp_valid, rsp_data, req_ready);
      end
      tick();
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (rd_cnt !== CW'(exp_rd)) begin
      errors++;
      $display("FAIL bp_no_count: rd_cnt=%0d required %0d", rd_cnt, exp_rd);
    end
    rsp_ready = 1'b1;
    tick();
    exp_rd++;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rd_cnt !== CW'(exp_rd)) begin
      errors++;
      $display("FAIL bp_release: valid=%0b ready=%0b rd_cnt=%0d required 0 1 %0d",
               rsp_valid, req_ready, rd_cnt, exp_rd);
    end
  endtask

  task automatic test_boundary();
    logic [DW-1:0] d;
    int lat;
    do_write(4'd15, 8'hFF);
    do_write(4'd0, 8'h00);
    do_read(4'd15, d, lat);
    checks++;
    if (d !== 8'hFF) begin
      errors++;
      $display("FAIL boundary_addr15: got %0h required ff", d);
    end
    do_read(4'd0, d, lat);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL boundary_addr0: got %0h required 00", d);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [DW-1:0] d;
    int lat;
    rsp_ready = 1'b1;
    present(1'b0, 4'd15, '0);   // now in RD
    tick();                     // now in CAP
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || wr_cnt !== '0 || rd_cnt !== '0 || ram_addr !== '0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midread_reset: valid=%0b wr=%0d rd=%0d addr=%0h ready=%0b required 0 0 0 0 1",
               rsp_valid, wr_cnt, rd_cnt, ram_addr, req_ready);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    exp_wr = 0;
    exp_rd = 0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midread_after_release: rsp_valid=%0b required 0", rsp_valid);
    end
    do_read(4'd15, d, lat);
    checks++;
    if (d !== 8'hFF || rd_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL midread_ram_kept: data=%0h rd_cnt=%0d required ff 1", d, rd_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    logic [1:0] seq [5];
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_write(AW'(i + 8), DW'(i));
      checks++;
      if (wr_cnt2 !== seq[i] || wr_cnt !== CW'(i + 1)) begin
        errors++;
        $display("FAIL wrap_step_%0d: cnt2=%0d cnt16=%0d required %0d %0d", i, wr_cnt2, wr_cnt, seq[i], i + 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_boundary();
    test_reset_mid_read();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
